// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
//
// Match sequencer for the pong game. It turns the datapath's raw edge-crossing
// events into an ordered serve -> rally -> point -> serve flow. It also holds
// the only authoritative score registers.
//
// Every output is registered. Each registered output is loaded from the value
// that matches the state being entered, so it changes on the same tick as
// `state`.
//
// Ports:
//   clk_div      in   game tick clock (only clock)
//   rst_n        in   synchronous, active-low reset
//   start        in   button level; only rising edges act
//   pause        in   level; freezes the game while high during a rally
//   hit_left     in   ball crossed the left edge (player scores)
//   hit_right    in   ball crossed the right edge (opponent scores)
//   ball_load    out  one-tick pulse: reload ball/paddles to centre
//   ball_run     out  datapath advance enable
//   serve_dir    out  initial ball x direction (1 = right, 0 = left)
//   score_player out  player points
//   score_opp    out  opponent points
//   score        out  {score_opp, score_player}
//   game_over    out  high while the match result is shown
//   state        out  current FSM state code
// ---------------------------------------------------------------------------
module pong_match_ctrl #(
   parameter int SERVE_DELAY = 30,
   parameter int WIN_SCORE   = 11
) (
   input  logic       clk_div,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       hit_left,
   input  logic       hit_right,
   output logic       ball_load,
   output logic       ball_run,
   output logic       serve_dir,
   output logic [3:0] score_player,
   output logic [3:0] score_opp,
   output logic [7:0] score,
   output logic       game_over,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_RALLY  = 3'd2;
   localparam logic [2:0] S_POINT  = 3'd3;
   localparam logic [2:0] S_PAUSED = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

   localparam logic [7:0] CNT_RELOAD = 8'(SERVE_DELAY - 1);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);

   // Scores stop at 15 instead of wrapping back to 0.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] sp_q, sp_d;
   logic [3:0] so_q, so_d;
   logic       dir_q, dir_d;
   logic       load_q, load_d;
   logic       run_q, run_d;
   logic       go_q, go_d;
   logic       start_q;
   logic       start_rise;

   assign start_rise = start & ~start_q;

   // State and registered outputs
   always_ff @(posedge clk_div) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         sp_q    <= 4'd0;
         so_q    <= 4'd0;
         dir_q   <= 1'b1;
         load_q  <= 1'b0;
         run_q   <= 1'b0;
         go_q    <= 1'b0;
         // Reset to 1 so that a button already held at reset does not start a match.
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sp_q    <= sp_d;
         so_q    <= so_d;
         dir_q   <= dir_d;
         load_q  <= load_d;
         run_q   <= run_d;
         go_q    <= go_d;
         start_q <= start;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_rise) state_d = S_SERVE;
         S_SERVE:  if (cnt_q == 8'd0) state_d = S_RALLY;
         S_RALLY: begin
            if (hit_left && hit_right)     state_d = S_SERVE;
            else if (hit_left || hit_right) state_d = S_POINT;
            else if (pause)                 state_d = S_PAUSED;
         end
         S_POINT: begin
            if (sp_q == WIN || so_q == WIN) state_d = S_OVER;
            else                            state_d = S_SERVE;
         end
         S_PAUSED: if (!pause) state_d = S_RALLY;
         S_OVER:   if (start_rise) state_d = S_SERVE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output / datapath-register next values
   always_comb begin
      cnt_d  = cnt_q;
      sp_d   = sp_q;
      so_d   = so_q;
      dir_d  = dir_q;
      // SERVE is only entered from another state, so this pulse never lasts two ticks.
      load_d = (state_d == S_SERVE) && (state_q != S_SERVE);
      run_d  = (state_d == S_RALLY);
      go_d   = (state_d == S_OVER);
      case (state_q)
         S_IDLE: begin
            sp_d = 4'd0;
            so_d = 4'd0;
            if (start_rise) begin
               dir_d = 1'b1;
               cnt_d = CNT_RELOAD;
            end
         end
         S_SERVE: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
         S_RALLY: begin
            if (hit_left && hit_right) begin
               cnt_d = CNT_RELOAD;
            end else if (hit_left) begin
               sp_d  = sat_inc(sp_q);
               dir_d = 1'b0;              // serve toward the loser
            end else if (hit_right) begin
               so_d  = sat_inc(so_q);
               dir_d = 1'b1;
            end
         end
         S_POINT: if (state_d == S_SERVE) cnt_d = CNT_RELOAD;
         S_OVER: begin
            if (start_rise) begin
               sp_d  = 4'd0;
               so_d  = 4'd0;
               dir_d = 1'b1;
               cnt_d = CNT_RELOAD;
            end
         end
         default: ;
      endcase
   end

   assign ball_load    = load_q;
   assign ball_run     = run_q;
   assign serve_dir    = dir_q;
   assign score_player = sp_q;
   assign score_opp    = so_q;
   assign score        = {so_q, sp_q};
   assign game_over    = go_q;
   assign state        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pong_match_ctrl.
//
// Instance A (SERVE_DELAY=3, WIN_SCORE=2) runs a table of per-tick vectors.
// Instance B (SERVE_DELAY=1, WIN_SCORE=15) builds up an 8'h35 score and is
// then reset in the middle of a rally.
// ---------------------------------------------------------------------------
module tb_pong_match_ctrl;

   logic clk_div = 1'b0;
   always #5 clk_div = ~clk_div;

   // Instance A signals
   logic       rst_n, start, pause, hit_left, hit_right;
   logic       ball_load, ball_run, serve_dir, game_over;
   logic [3:0] score_player, score_opp;
   logic [7:0] score;
   logic [2:0] state;

   // Instance B signals
   logic       rst_n_b, start_b, pause_b, hl_b, hr_b;
   logic       load_b, run_b, dir_b, go_b;
   logic [3:0] sp_b, so_b;
   logic [7:0] score_b;
   logic [2:0] state_b;

   pong_match_ctrl #(.SERVE_DELAY(3), .WIN_SCORE(2)) u_a (
      .clk_div(clk_div), .rst_n(rst_n), .start(start), .pause(pause),
      .hit_left(hit_left), .hit_right(hit_right), .ball_load(ball_load),
      .ball_run(ball_run), .serve_dir(serve_dir), .score_player(score_player),
      .score_opp(score_opp), .score(score), .game_over(game_over), .state(state)
   );

   pong_match_ctrl #(.SERVE_DELAY(1), .WIN_SCORE(15)) u_b (
      .clk_div(clk_div), .rst_n(rst_n_b), .start(start_b), .pause(pause_b),
      .hit_left(hl_b), .hit_right(hr_b), .ball_load(load_b),
      .ball_run(run_b), .serve_dir(dir_b), .score_player(sp_b),
      .score_opp(so_b), .score(score_b), .game_over(go_b), .state(state_b)
   );

   typedef struct {
      logic        rst_n, start, pause, hl, hr;
      logic [14:0] exp;   // {ball_load, ball_run, serve_dir, score, game_over, state}
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic add(input logic r, s, p, l, h,
                      input logic ld, rn, dr, input logic [7:0] sc,
                      input logic go, input logic [2:0] st);
      vec_t v;
      v.rst_n = r; v.start = s; v.pause = p; v.hl = l; v.hr = h;
      v.exp = {ld, rn, dr, sc, go, st};
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got load=%b run=%b dir=%b score=%h over=%b state=%0d, expected load=%b run=%b dir=%b score=%h over=%b state=%0d",
                    name, got[14], got[13], got[12], got[11:4], got[3], got[2:0],
                    exp[14], exp[13], exp[12], exp[11:4], exp[3], exp[2:0]);
   endtask

   task automatic tick;
      @(posedge clk_div);
      #1;
   endtask

   function automatic logic [14:0] outs_b();
      return {load_b, run_b, dir_b, score_b, go_b, state_b};
   endfunction

   // One point on B from RALLY: hit -> POINT -> SERVE (1 tick) -> RALLY.
   task automatic b_point(input logic left, input string name);
      hl_b = left; hr_b = ~left;
      tick;
      hl_b = 1'b0; hr_b = 1'b0;
      tick;
      tick;
      n_checks++;
      if (state_b === 3'd2 && run_b === 1'b1) n_pass++;
      else $display("FAIL %s: got state=%0d run=%b, expected state=2 run=1", name, state_b, run_b);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
      rst_n_b = 1'b0; start_b = 1'b0; pause_b = 1'b0; hl_b = 1'b0; hr_b = 1'b0;

      //   rst st pa hl hr   load run dir score  over state
      add(0, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);  // reset values
      add(0, 1, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);  // start held through reset
      add(1, 1, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);  // no rise after release
      add(1, 1, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);  // button falls
      add(1, 1, 0, 0, 0,   1, 0, 1, 8'h00, 0, 1);  // rise: SERVE + load
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 1);
      add(1, 0, 0, 1, 0,   0, 0, 1, 8'h00, 0, 1);  // hit ignored in SERVE
      add(1, 0, 1, 0, 0,   0, 1, 1, 8'h00, 0, 2);  // pause ignored; 3rd tick -> RALLY
      add(1, 0, 0, 0, 0,   0, 1, 1, 8'h00, 0, 2);
      add(1, 0, 0, 1, 0,   0, 0, 0, 8'h01, 0, 3);  // hit_left -> POINT
      add(1, 0, 0, 0, 0,   1, 0, 0, 8'h01, 0, 1);  // SERVE + load
      add(1, 0, 0, 0, 0,   0, 0, 0, 8'h01, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 0, 8'h01, 0, 1);
      add(1, 0, 0, 0, 0,   0, 1, 0, 8'h01, 0, 2);
      add(1, 0, 0, 0, 1,   0, 0, 1, 8'h11, 0, 3);  // hit_right -> POINT
      add(1, 0, 0, 0, 0,   1, 0, 1, 8'h11, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h11, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h11, 0, 1);
      add(1, 0, 0, 0, 0,   0, 1, 1, 8'h11, 0, 2);
      add(1, 0, 1, 0, 0,   0, 0, 1, 8'h11, 0, 4);  // pause -> PAUSED
      add(1, 0, 1, 1, 0,   0, 0, 1, 8'h11, 0, 4);  // hit ignored while paused
      add(1, 0, 0, 0, 0,   0, 1, 1, 8'h11, 0, 2);  // pause low -> RALLY
      add(1, 0, 0, 1, 1,   1, 0, 1, 8'h11, 0, 1);  // both hits: no score, reserve
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h11, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h11, 0, 1);
      add(1, 0, 0, 0, 0,   0, 1, 1, 8'h11, 0, 2);
      add(1, 0, 1, 0, 1,   0, 0, 1, 8'h21, 0, 3);  // hit beats pause
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h21, 1, 5);  // opp reached 2 -> OVER
      add(1, 0, 0, 1, 0,   0, 0, 1, 8'h21, 1, 5);  // frozen
      add(1, 0, 1, 0, 1,   0, 0, 1, 8'h21, 1, 5);
      add(1, 1, 0, 0, 0,   1, 0, 1, 8'h00, 0, 1);  // restart clears scores
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 1);
      add(1, 0, 0, 0, 0,   0, 1, 1, 8'h00, 0, 2);
      add(1, 0, 0, 1, 0,   0, 0, 0, 8'h01, 0, 3);
      add(1, 0, 0, 0, 0,   1, 0, 0, 8'h01, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 0, 8'h01, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 0, 8'h01, 0, 1);
      add(1, 0, 0, 0, 0,   0, 1, 0, 8'h01, 0, 2);
      add(1, 0, 0, 1, 0,   0, 0, 0, 8'h02, 0, 3);
      add(1, 0, 0, 0, 0,   0, 0, 0, 8'h02, 1, 5);  // player wins
      add(1, 0, 0, 1, 1,   0, 0, 0, 8'h02, 1, 5);
      add(1, 1, 0, 0, 0,   1, 0, 1, 8'h00, 0, 1);
      add(1, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 1);
      add(0, 0, 0, 0, 0,   0, 0, 1, 8'h00, 0, 0);  // reset during SERVE

      foreach (vq[i]) begin
         rst_n = vq[i].rst_n; start = vq[i].start; pause = vq[i].pause;
         hit_left = vq[i].hl; hit_right = vq[i].hr;
         tick;
         check($sformatf("vec%0d", i),
               {ball_load, ball_run, serve_dir, score, game_over, state}, vq[i].exp);
         n_checks++;
         if (score === {score_opp, score_player}) n_pass++;
         else $display("FAIL pack%0d: got score=%h, expected %h", i, score, {score_opp, score_player});
      end

      // Instance B: reach 8'h35, then reset mid-rally
      rst_n_b = 1'b0;
      tick;
      check("b_reset", outs_b(), {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0});
      rst_n_b = 1'b1;
      tick;
      start_b = 1'b1;
      tick;
      check("b_start", outs_b(), {1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1});
      start_b = 1'b0;
      tick;
      check("b_rally", outs_b(), {1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 3'd2});
      for (int k = 0; k < 5; k++) b_point(1'b1, $sformatf("b_left%0d", k));
      for (int k = 0; k < 3; k++) b_point(1'b0, $sformatf("b_right%0d", k));
      check("b_score35", outs_b(), {1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 3'd2});
      rst_n_b = 1'b0; hl_b = 1'b1;
      tick;
      check("b_midrally_rst", outs_b(), {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0});
      hl_b = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
